// File: rtl/control_unit_mc_pkg.sv
// Shared types and constants for the multi-cycle accumulator control unit.
// State codes are externally visible through the scan chain, so they are fixed.
package control_unit_pkg;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_FETCH   = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_HALT    = 3'd4,
    ST_FAULT   = 3'd5,
    ST_BAD6    = 3'd6,
    ST_BAD7    = 3'd7
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_JMP   = 4'h3;
  localparam logic [3:0] OP_ALUI  = 4'h4;
  localparam logic [3:0] OP_ALUM  = 4'h5;
  localparam logic [3:0] OP_JZ    = 4'h6;

  localparam logic [1:0] PC_SEL_HOLD   = 2'b00;
  localparam logic [1:0] PC_SEL_INC    = 2'b01;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b10;

  localparam logic [1:0] ACC_SEL_HOLD = 2'b00;
  localparam logic [1:0] ACC_SEL_ALU  = 2'b01;
  localparam logic [1:0] ACC_SEL_MEM  = 2'b10;

  localparam logic [1:0] ADDR_SEL_PC   = 2'b00;
  localparam logic [1:0] ADDR_SEL_OPND = 2'b01;

  // Raw per-state control bundle, before the scan/enable gating is applied.
  typedef struct packed {
    logic       mem_req;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       acc_we;
    logic [1:0] acc_sel;
    logic       ir_ld;
    logic       inb_imm;
    logic       mem_we;
    logic [1:0] addr_sel;
  } ctrl_t;

  function automatic logic is_mem_phase(state_t s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/control_unit_mc_mem_wait_timer.sv
// Counts stalled memory cycles and flags the cycle in which the wait limit is hit.
// The counter saturates at TIMEOUT so a restored scan state can never wrap it.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int            CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit            EN    = (TIMEOUT > 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                      cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (inc && cnt < LIMIT)  cnt <= cnt + CW'(1);
  end

  // Fires in the stalled cycle whose increment would reach TIMEOUT.
  assign expire = EN && inc && (cnt >= LAST);

endmodule

// File: rtl/control_unit_mc.sv
// Multi-cycle control unit: FETCH/EXECUTE/MEM sequencing over a req/ready memory
// port, ZF branching, retired-instruction counter and a 3-bit state scan chain.
module control_unit_mc
  import control_unit_pkg::*;
#(
  parameter int INSTR_W  = 8,
  parameter int OPC_W    = 4,
  parameter int ALU_OP_W = 4,
  parameter int TIMEOUT  = 15,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                processor_enable,
  input  logic [INSTR_W-1:0]  instruction,
  input  logic                ZF,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                PC_write_enable,
  output logic [1:0]          PC_mux_select,
  output logic                ACC_write_enable,
  output logic [1:0]          ACC_mux_select,
  output logic                IR_load_enable,
  output logic [ALU_OP_W-1:0] ALU_opcode,
  output logic                ALU_inputB_mux_select,
  output logic                Memory_write_enable,
  output logic [1:0]          Memory_address_mux_select,
  output logic                processor_halted,
  output logic                fault,
  output logic [CNT_W-1:0]    retired_count,
  input  logic                scan_enable,
  input  logic                scan_in,
  output logic                scan_out
);

  state_t              state, state_nxt;
  ctrl_t               ctl;
  logic [ALU_OP_W-1:0] alu_fn;
  logic [OPC_W-1:0]    opc;
  logic                halt_instr, active, wt_inc, wt_clr, expire, retire;

  assign opc        = instruction[INSTR_W-1 -: OPC_W];
  assign halt_instr = &instruction;
  assign active     = processor_enable & ~scan_enable;
  assign wt_inc     = active & is_mem_phase(state) & ~mem_ready;
  assign wt_clr     = active & (state_nxt != state) & is_mem_phase(state_nxt);
  assign retire     = active & (state == ST_EXECUTE || state == ST_MEM)
                             & (state_nxt == ST_FETCH || state_nxt == ST_HALT);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk    (clk),
    .rst    (rst),
    .clr    (wt_clr),
    .inc    (wt_inc),
    .expire (expire)
  );

  always_comb begin
    ctl       = '0;
    alu_fn    = '0;
    state_nxt = state;
    case (state)
      ST_RESET: state_nxt = ST_FETCH;
      ST_FETCH: begin
        ctl.mem_req  = 1'b1;
        ctl.addr_sel = ADDR_SEL_PC;
        if (mem_ready) begin
          ctl.ir_ld  = 1'b1;
          ctl.pc_we  = 1'b1;
          ctl.pc_sel = PC_SEL_INC;
          state_nxt  = ST_EXECUTE;
        end else if (expire) begin
          state_nxt  = ST_FAULT;
        end
      end
      ST_EXECUTE: begin
        alu_fn    = instruction[ALU_OP_W-1:0];
        state_nxt = ST_FETCH;
        // All-ones must be caught before the opcode decode claims it as illegal.
        if (halt_instr) begin
          state_nxt = ST_HALT;
        end else begin
          case (opc)
            OPC_W'(OP_NOP): ;
            OPC_W'(OP_JMP): begin
              ctl.pc_we  = 1'b1;
              ctl.pc_sel = PC_SEL_BRANCH;
            end
            OPC_W'(OP_JZ): begin
              ctl.pc_we  = ZF;
              ctl.pc_sel = PC_SEL_BRANCH;
            end
            OPC_W'(OP_ALUI): begin
              ctl.acc_we  = 1'b1;
              ctl.acc_sel = ACC_SEL_ALU;
              ctl.inb_imm = 1'b1;
            end
            OPC_W'(OP_LOAD), OPC_W'(OP_STORE), OPC_W'(OP_ALUM): state_nxt = ST_MEM;
            default: state_nxt = ST_FAULT;
          endcase
        end
      end
      ST_MEM: begin
        alu_fn       = instruction[ALU_OP_W-1:0];
        ctl.mem_req  = 1'b1;
        ctl.addr_sel = ADDR_SEL_OPND;
        ctl.mem_we   = (opc == OPC_W'(OP_STORE));
        if (mem_ready) begin
          if (opc == OPC_W'(OP_LOAD)) begin
            ctl.acc_we  = 1'b1;
            ctl.acc_sel = ACC_SEL_MEM;
          end else if (opc == OPC_W'(OP_ALUM)) begin
            ctl.acc_we  = 1'b1;
            ctl.acc_sel = ACC_SEL_ALU;
          end
          state_nxt = ST_FETCH;
        end else if (expire) begin
          state_nxt = ST_FAULT;
        end
      end
      ST_HALT, ST_FAULT: ;
      default: state_nxt = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_RESET;
      retired_count <= '0;
    end else if (scan_enable) begin
      state         <= state_t'({state[1:0], scan_in});
    end else if (processor_enable) begin
      state         <= state_nxt;
      if (retire) retired_count <= retired_count + CNT_W'(1);
    end
  end

  // Strobes are gated so scan shifting or a frozen core never touches memory or regs.
  assign mem_req                   = ctl.mem_req & active;
  assign PC_write_enable           = ctl.pc_we   & active;
  assign ACC_write_enable          = ctl.acc_we  & active;
  assign IR_load_enable            = ctl.ir_ld   & active;
  assign Memory_write_enable       = ctl.mem_we  & active;
  assign PC_mux_select             = ctl.pc_sel;
  assign ACC_mux_select            = ctl.acc_sel;
  assign ALU_inputB_mux_select     = ctl.inb_imm;
  assign Memory_address_mux_select = ctl.addr_sel;
  assign ALU_opcode                = alu_fn;
  assign processor_halted          = (state == ST_HALT) || (state == ST_FAULT);
  assign fault                     = (state == ST_FAULT);
  assign scan_out                  = state[2];

endmodule

// File: doc/control_unit_mc.md
Name: control_unit_mc

Overview:
- Parametrised multi-cycle successor to the accumulator-machine control unit.
- Sequences FETCH/EXECUTE/MEM phases over a req/ready memory handshake with a wait-timeout fault.
- Adds conditional branching on ZF, a retired-instruction counter and a real state scan chain.
- Sits between the instruction register/datapath muxes and the shared memory port.

Parameters:
INSTR_W, 8, instruction width (>= OPC_W + ALU_OP_W)
OPC_W, 4, opcode field width; opcode = instruction[INSTR_W-1 -: OPC_W]
ALU_OP_W, 4, ALU function field; instruction[ALU_OP_W-1:0]
TIMEOUT, 15, max cycles to wait for mem_ready; 0 disables timeout
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
processor_enable  in  1  0 freezes FSM and counters
instruction  in  INSTR_W  current IR contents
ZF  in  1  zero flag from datapath
mem_ready  in  1  memory completes access this cycle
mem_req  out  1  memory access request
PC_write_enable  out  1  PC load
PC_mux_select  out  2  00 hold, 01 PC+1, 10 branch target
ACC_write_enable  out  1  ACC load
ACC_mux_select  out  2  00 hold, 01 ALU, 10 memory data
IR_load_enable  out  1  IR load
ALU_opcode  out  ALU_OP_W  ALU function
ALU_inputB_mux_select  out  1  1 immediate, 0 memory data
Memory_write_enable  out  1  store strobe
Memory_address_mux_select  out  2  00 PC, 01 operand address
processor_halted  out  1  state is HALT or FAULT
fault  out  1  state is FAULT
retired_count  out  CNT_W  instructions completed, wraps
scan_enable  in  1  scan shift mode
scan_in  in  1  scan data in
scan_out  out  1  scan data out = state[2]

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
  - On reset: state=RESET, wait counter=0, retired_count=0.
  - All outputs are 0 after reset; scan_out = 0.
- State encoding (3 bits): RESET=0, FETCH=1, EXECUTE=2, MEM=3, HALT=4, FAULT=5. Codes 6 and 7 go to FAULT on the next active cycle.
- Priority per cycle: rst > scan_enable > processor_enable=0 > normal.
- Scan: state <= {state[1:0], scan_in}. FSM, counters and all enables are frozen, and mem_req=0.
- processor_enable=0: state and counters hold; all write/load enables and mem_req are 0.
- Outputs are Moore/Mealy from the current state; any output not listed in a state is 0.
- RESET: advance to FETCH.
- FETCH:
  - mem_req=1, address mux=00.
  - On mem_ready: IR_load_enable=1, PC_write_enable=1, PC_mux_select=01, go to EXECUTE.
- EXECUTE: ALU_opcode = instruction[ALU_OP_W-1:0] here and in MEM, 0 elsewhere. Decode on opcode:
  - 0x0 NOP: go to FETCH.
  - 0x3 JMP: PC_write_enable=1, mux=10, go to FETCH.
  - 0x6 JZ: PC_write_enable=ZF, mux=10, go to FETCH.
  - 0x4 ALUI: ACC_write_enable=1, ACC mux=01, inputB=1, go to FETCH.
  - 0x1 LOAD, 0x2 STORE, 0x5 ALUM: go to MEM.
  - instruction all-ones: go to HALT.
  - Any other opcode: go to FAULT.
- MEM:
  - mem_req=1, address mux=01.
  - STORE: Memory_write_enable=1 for every MEM cycle.
  - On mem_ready:
    - LOAD: ACC_write_enable=1, mux=10.
    - ALUM: ACC_write_enable=1, mux=01, inputB=0.
    - Then go to FETCH.
- Wait counter:
  - Cleared on entering FETCH or MEM.
  - Increments each active cycle with mem_req=1 and mem_ready=0.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT with mem_ready still 0: go to FAULT.
  - mem_ready in the same cycle as expiry wins and completes normally.
- retired_count: +1 (mod 2^CNT_W) on every transition EXECUTE->FETCH, MEM->FETCH or EXECUTE->HALT.
- HALT and FAULT are absorbing; only rst exits them. mem_ready is ignored outside FETCH/MEM.
- Reset mid-access: mem_req drops on the next cycle, with no write strobe.

Decomposition:
- Package control_unit_pkg holds:
  - state typedef/codes;
  - opcode constants (OP_NOP, OP_LOAD, OP_STORE, OP_JMP, OP_ALUI, OP_ALUM, OP_JZ);
  - mux select constants (PC_SEL_*, ACC_SEL_*, ADDR_SEL_*).
- One sub-module, mem_wait_timer: wait counter plus expiry compare, parametrised by TIMEOUT.

Test Plan:
- Reset, then program ALUI 0x43 (mem_ready tied 1) -> 2-cycle FETCH->EXECUTE; ACC_write_enable=1, ALU_opcode=3, ALU_inputB_mux_select=1; retired_count=1.
- LOAD 0x10 with mem_ready delayed 3 cycles in MEM -> mem_req high 4 cycles, ACC_write_enable pulse only in the ready cycle with mux=10; TIMEOUT=15 no fault.
- JZ 0x60 with ZF=0, then ZF=1 -> PC_write_enable 0 then 1 with PC_mux_select=10.
- FETCH with mem_ready never asserted, TIMEOUT=15 -> fault=1 and processor_halted=1 after 15 wait cycles; count unchanged; rst recovers to RESET.
- Instruction 0xFF -> HALT, retired_count increments, state holds for 50 cycles. Opcode 0x9 -> FAULT.
- scan_enable=1 for 3 cycles shifting 1,0,1 -> state becomes 5 (FAULT), scan_out emits the old state MSB first. processor_enable=0 mid-MEM -> all enables 0, state held.
